// File: rtl/onchip_mem_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// onchip_mem_pkg : shared defaults and port identifiers for the RAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package onchip_mem_pkg;

  localparam int          DEF_ADDR_W    = 15;
  localparam int          DEF_DATA_W    = 32;
  localparam int unsigned DEF_MEM_WORDS = 17740;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  function automatic port_id_e other_port(input port_id_e p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_mem_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// onchip_mem_arbiter_if : requester ports A/B, RAM command bus and error flag
// Rev 1.0
// ----------------------------------------------------------------------------
interface onchip_mem_arbiter_if
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0]   a_address;
  logic [DATA_W/8-1:0] a_byteenable;
  logic                a_read;
  logic                a_write;
  logic [DATA_W-1:0]   a_writedata;
  logic                a_waitrequest;
  logic [DATA_W-1:0]   a_readdata;
  logic                a_readdatavalid;

  logic [ADDR_W-1:0]   b_address;
  logic [DATA_W/8-1:0] b_byteenable;
  logic                b_read;
  logic                b_write;
  logic [DATA_W-1:0]   b_writedata;
  logic                b_waitrequest;
  logic [DATA_W-1:0]   b_readdata;
  logic                b_readdatavalid;

  logic [ADDR_W-1:0]   mem_address;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W-1:0]   mem_readdata;
  logic                mem_clken;

  logic                err_oor;

  modport slave (
    input  a_address, a_byteenable, a_read, a_write, a_writedata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_byteenable, b_read, b_write, b_writedata,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    input  mem_readdata,
    output mem_clken, err_oor
  );

  modport master (
    output a_address, a_byteenable, a_read, a_write, a_writedata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_byteenable, b_read, b_write, b_writedata,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata,
    output mem_readdata,
    input  mem_clken, err_oor
  );

endinterface
`default_nettype wire

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-requester round-robin arbiter, last winner remembered
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2
  import onchip_mem_pkg::*;
(
  input  wire  clk,
  input  wire  reset_n,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  port_id_e last_grant_q;
  port_id_e last_grant_d;

  always_comb begin
    gnt_a_o      = 1'b0;
    gnt_b_o      = 1'b0;
    last_grant_d = last_grant_q;
    if (req_a_i && req_b_i) begin
      // Contention: the port that did not win last time goes first.
      if (other_port(last_grant_q) == PORT_A) gnt_a_o = 1'b1;
      else                                    gnt_b_o = 1'b1;
    end else begin
      gnt_a_o = req_a_i;
      gnt_b_o = req_b_i;
    end
    if (gnt_a_o)      last_grant_d = PORT_A;
    else if (gnt_b_o) last_grant_d = PORT_B;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_grant_q <= PORT_B;
    else          last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/onchip_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// onchip_mem_arbiter : two-port round-robin arbiter in front of a shared RAM
// Rev 1.0
// ----------------------------------------------------------------------------
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int          ADDR_W    = DEF_ADDR_W,
  parameter int          DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
  input wire                   clk,
  input wire                   reset_n,
  onchip_mem_arbiter_if.slave  bus_io
);

  localparam int BE_W = DATA_W / 8;

  logic              w_a_req_raw, w_b_req_raw;
  logic              w_a_req, w_b_req;
  logic              w_gnt_a, w_gnt_b;
  logic              w_issue;
  logic [ADDR_W-1:0] w_win_addr;
  logic [BE_W-1:0]   w_win_be;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_write;
  logic              w_oor;
  logic              w_access;

  logic     rd_pending_q, rd_pending_d;
  port_id_e rd_owner_q,   rd_owner_d;
  logic     rd_oor_q,     rd_oor_d;

  assign w_a_req_raw = bus_io.a_read | bus_io.a_write;
  assign w_b_req_raw = bus_io.b_read | bus_io.b_write;
  // Nothing may be granted while reset is asserted.
  assign w_a_req     = w_a_req_raw & reset_n;
  assign w_b_req     = w_b_req_raw & reset_n;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req_a_i (w_a_req),
    .req_b_i (w_b_req),
    .gnt_a_o (w_gnt_a),
    .gnt_b_o (w_gnt_b)
  );

  assign w_issue     = w_gnt_a | w_gnt_b;
  assign w_win_addr  = w_gnt_b ? bus_io.b_address    : bus_io.a_address;
  assign w_win_be    = w_gnt_b ? bus_io.b_byteenable : bus_io.a_byteenable;
  assign w_win_wdata = w_gnt_b ? bus_io.b_writedata  : bus_io.a_writedata;
  assign w_win_write = w_gnt_b ? bus_io.b_write      : bus_io.a_write;
  assign w_oor       = 32'(w_win_addr) >= MEM_WORDS;
  assign w_access    = w_issue & ~w_oor;

  assign bus_io.a_waitrequest = w_a_req_raw & ~w_gnt_a;
  assign bus_io.b_waitrequest = w_b_req_raw & ~w_gnt_b;

  assign bus_io.mem_clken      = reset_n;
  assign bus_io.mem_chipselect = w_access;
  assign bus_io.mem_write      = w_access & w_win_write;
  assign bus_io.mem_address    = w_win_addr;
  assign bus_io.mem_byteenable = w_win_write ? w_win_be : {BE_W{1'b1}};
  assign bus_io.mem_writedata  = w_win_data_sel();
  assign bus_io.err_oor        = w_issue & w_oor;

  function automatic logic [DATA_W-1:0] w_win_data_sel();
    return w_win_wdata;
  endfunction

  always_comb begin
    rd_pending_d = w_issue & ~w_win_write;
    rd_owner_d   = rd_owner_q;
    rd_oor_d     = rd_oor_q;
    if (w_issue && !w_win_write) begin
      rd_owner_d = w_gnt_b ? PORT_B : PORT_A;
      rd_oor_d   = w_oor;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending_q <= 1'b0;
      rd_owner_q   <= PORT_A;
      rd_oor_q     <= 1'b0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
    end
  end

  // Out-of-range reads never touched the RAM, so their response is forced to zero.
  assign bus_io.a_readdatavalid = rd_pending_q & (rd_owner_q == PORT_A);
  assign bus_io.b_readdatavalid = rd_pending_q & (rd_owner_q == PORT_B);
  assign bus_io.a_readdata = (bus_io.a_readdatavalid && !rd_oor_q) ? bus_io.mem_readdata : '0;
  assign bus_io.b_readdata = (bus_io.b_readdatavalid && !rd_oor_q) ? bus_io.mem_readdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_onchip_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_onchip_mem_arbiter : scoreboard bench with RAM model and reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int          ADDR_W    = 15;
  localparam int          DATA_W    = 32;
  localparam int unsigned MEM_WORDS = 17740;

  typedef struct {
    bit        v;
    bit        rd;
    bit        wr;
    bit [14:0] addr;
    bit [3:0]  be;
    bit [31:0] wd;
  } req_t;

  typedef struct {
    bit        wait_a, wait_b, cs, we, err, clken, rdv_a, rdv_b;
    bit [14:0] addr;
    bit [3:0]  be;
    bit [31:0] wd, rd_a, rd_b;
  } exp_t;

  logic clk;
  logic reset_n;

  onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  onchip_mem_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_WORDS (MEM_WORDS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus_io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: address registered, output unregistered
  logic [31:0] ram [0:MEM_WORDS-1];
  logic [14:0] ram_addr_q;
  always @(posedge clk) begin
    if (bus.mem_clken && bus.mem_chipselect && (32'(bus.mem_address) < MEM_WORDS)) begin
      if (bus.mem_write)
        for (int i = 0; i < 4; i++)
          if (bus.mem_byteenable[i]) ram[bus.mem_address][8*i +: 8] <= bus.mem_writedata[8*i +: 8];
      ram_addr_q <= bus.mem_address;
    end
  end
  assign bus.mem_readdata = (32'(ram_addr_q) < MEM_WORDS) ? ram[ram_addr_q] : 32'h0;

  // Reference model state
  bit [31:0] mm [int];
  bit        last_b = 1'b1;
  bit        pend_v, pend_b;
  bit [31:0] pend_d;
  bit        rst_val;
  req_t      cur_a, cur_b;
  exp_t      expq [$];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic bit [31:0] mrd(input bit [14:0] a);
    return mm.exists(int'(a)) ? mm[int'(a)] : 32'h0;
  endfunction

  function automatic req_t mk(input bit rd, input bit wr, input int addr,
                              input bit [3:0] be, input bit [31:0] wd);
    req_t r;
    r.v = 1'b1; r.rd = rd; r.wr = wr; r.addr = 15'(addr); r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rnd_req();
    int k;
    int a;
    k = int'($urandom_range(0, 2));
    if ($urandom_range(0, 7) == 0) a = int'($urandom_range(MEM_WORDS, 32767));
    else                           a = int'($urandom_range(0, 31));
    return mk(k != 1, k != 0, a, 4'($urandom_range(0, 15)), $urandom);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive();
    bus.a_read       = cur_a.v & cur_a.rd;
    bus.a_write      = cur_a.v & cur_a.wr;
    bus.a_address    = cur_a.addr;
    bus.a_byteenable = cur_a.be;
    bus.a_writedata  = cur_a.wd;
    bus.b_read       = cur_b.v & cur_b.rd;
    bus.b_write      = cur_b.v & cur_b.wr;
    bus.b_address    = cur_b.addr;
    bus.b_byteenable = cur_b.be;
    bus.b_writedata  = cur_b.wd;
  endtask

  // One clock of stimulus plus the model's prediction for that clock.
  task automatic step();
    exp_t      e;
    req_t      w;
    bit        ra, rb, ga, gb, oor, nv, nb;
    bit [31:0] nd, old;
    @(posedge clk);
    #1;
    reset_n = rst_val;
    drive();
    e = '{default: 0};
    e.clken = rst_val;
    if (rst_val && pend_v) begin
      if (pend_b) begin e.rdv_b = 1'b1; e.rd_b = pend_d; end
      else        begin e.rdv_a = 1'b1; e.rd_a = pend_d; end
    end
    ra = cur_a.v && rst_val;
    rb = cur_b.v && rst_val;
    ga = 1'b0; gb = 1'b0;
    if (ra && rb) begin
      if (last_b) ga = 1'b1; else gb = 1'b1;
    end else begin
      ga = ra; gb = rb;
    end
    if (!rst_val) last_b = 1'b1;
    else if (ga)  last_b = 1'b0;
    else if (gb)  last_b = 1'b1;
    e.wait_a = cur_a.v && !ga;
    e.wait_b = cur_b.v && !gb;
    nv = 1'b0; nb = 1'b0; nd = 32'h0;
    if (ga || gb) begin
      w   = ga ? cur_a : cur_b;
      oor = 32'(w.addr) >= MEM_WORDS;
      e.err = oor;
      if (!oor) begin
        e.cs   = 1'b1;
        e.we   = w.wr;
        e.addr = w.addr;
        e.be   = w.wr ? w.be : 4'hF;
        if (w.wr) e.wd = w.wd;
      end
      if (w.wr && !oor) begin
        old = mrd(w.addr);
        for (int i = 0; i < 4; i++) if (w.be[i]) old[8*i +: 8] = w.wd[8*i +: 8];
        mm[int'(w.addr)] = old;
      end
      if (!w.wr) begin
        nv = 1'b1; nb = gb; nd = oor ? 32'h0 : mrd(w.addr);
      end
    end
    expq.push_back(e);
    if (ga) cur_a.v = 1'b0;
    if (gb) cur_b.v = 1'b0;
    pend_v = nv; pend_b = nb; pend_d = nd;
  endtask

  // Monitor: compares DUT outputs mid-cycle against the oldest prediction.
  exp_t me;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk("a_waitrequest",   32'(bus.a_waitrequest),   32'(me.wait_a));
      chk("b_waitrequest",   32'(bus.b_waitrequest),   32'(me.wait_b));
      chk("mem_clken",       32'(bus.mem_clken),       32'(me.clken));
      chk("mem_chipselect",  32'(bus.mem_chipselect),  32'(me.cs));
      chk("mem_write",       32'(bus.mem_write),       32'(me.we));
      chk("err_oor",         32'(bus.err_oor),         32'(me.err));
      chk("a_readdatavalid", 32'(bus.a_readdatavalid), 32'(me.rdv_a));
      chk("b_readdatavalid", 32'(bus.b_readdatavalid), 32'(me.rdv_b));
      chk("a_readdata",      bus.a_readdata,           me.rd_a);
      chk("b_readdata",      bus.b_readdata,           me.rd_b);
      if (me.cs) begin
        chk("mem_address",    32'(bus.mem_address),    32'(me.addr));
        chk("mem_byteenable", 32'(bus.mem_byteenable), 32'(me.be));
      end
      if (me.we) chk("mem_writedata", bus.mem_writedata, me.wd);
    end
  end

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = 32'h0;
    ram_addr_q = '0;
    reset_n = 1'b0;
    rst_val = 1'b0;
    cur_a = '{default: 0};
    cur_b = '{default: 0};
    drive();

    repeat (3) step();
    rst_val = 1'b1;
    step();

    // Single write then read-back on port A
    cur_a = mk(0, 1, 16, 4'hF, 32'h12345678); step();
    step();
    cur_a = mk(1, 0, 16, 4'hF, 32'h0); step();
    step();

    // Byte-lane write into a zeroed word
    cur_a = mk(0, 1, 5, 4'h4, 32'h00AA0000); step();
    cur_a = mk(1, 0, 5, 4'hF, 32'h0); step();
    step();

    // Out-of-range write and read on port B
    cur_b = mk(0, 1, 17740, 4'hF, 32'hDEADBEEF); step();
    cur_b = mk(1, 0, 17740, 4'hF, 32'h0); step();
    step();

    // Read followed by reset assertion: response must be dropped
    cur_a = mk(1, 0, 16, 4'hF, 32'h0); step();
    rst_val = 1'b0;
    step();
    step();
    rst_val = 1'b1;

    // Simultaneous reads right after reset: A first, then B
    cur_a = mk(1, 0, 16, 4'hF, 32'h0);
    cur_b = mk(1, 0, 5, 4'hF, 32'h0);
    for (int i = 0; i < 4 && (cur_a.v || cur_b.v); i++) step();

    // Both ports streaming reads for 16 cycles
    for (int i = 0; i < 16; i++) begin
      if (!cur_a.v) cur_a = mk(1, 0, int'($urandom_range(0, 31)), 4'hF, 32'h0);
      if (!cur_b.v) cur_b = mk(1, 0, int'($urandom_range(0, 31)), 4'hF, 32'h0);
      step();
    end
    cur_a.v = 1'b0;
    cur_b.v = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!cur_a.v && $urandom_range(0, 2) != 0) cur_a = rnd_req();
      if (!cur_b.v && $urandom_range(0, 2) != 0) cur_b = rnd_req();
      step();
    end
    cur_a.v = 1'b0;
    cur_b.v = 1'b0;
    repeat (3) step();
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/onchip_mem_arbiter.md
ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, word-address width of the shared RAM.
REQ-002 Parameter DATA_W, default 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 Parameter MEM_WORDS, default 17740, number of implemented words; addresses >= MEM_WORDS are out of range.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 a_address  in  ADDR_W; a_byteenable  in  DATA_W/8; a_read  in  1; a_write  in  1; a_writedata  in  DATA_W: port A (CPU) request.
REQ-008 a_waitrequest  out  1; a_readdata  out  DATA_W; a_readdatavalid  out  1: port A response.
REQ-009 b_* ports SHALL be identical to a_* (port B, UART/USB DMA requester).
REQ-010 mem_address  out  ADDR_W; mem_byteenable  out  DATA_W/8; mem_chipselect  out  1; mem_write  out  1; mem_writedata  out  DATA_W: RAM command.
REQ-011 mem_readdata  in  DATA_W: RAM output, valid one clk after the address cycle (address registered in RAM, output unregistered).
REQ-012 mem_clken  out  1: RAM clock enable, driven 1 except during reset.
REQ-013 err_oor  out  1: one-cycle pulse when an out-of-range access is consumed.

Function
REQ-014 A port is requesting when read or write is high; read and write both high SHALL be treated as write only.
REQ-015 At most one access SHALL be issued to the RAM per clk; issue is combinational in the cycle of the grant.
REQ-016 Arbitration SHALL be round-robin: a single-cycle tie goes to the port not granted last; last_grant register updates on every issue; reset value favours port A.
REQ-017 x_waitrequest SHALL equal x requesting AND NOT granted this cycle; a request is consumed in the cycle its waitrequest is low.
REQ-018 A non-requesting port SHALL see waitrequest low.
REQ-019 Requesters SHALL hold address/data/byteenable/command stable while waitrequest is high; arbiter does not register requests.
REQ-020 Granted write: mem_chipselect=1, mem_write=1, address/byteenable/writedata from winner, same cycle.
REQ-021 Granted read: mem_chipselect=1, mem_write=0, mem_byteenable all ones; rd_pending and rd_owner registered.
REQ-022 Read response: exactly one clk after issue, owner's readdatavalid=1 for one cycle with readdata=mem_readdata; other port readdatavalid=0.
REQ-023 Back-to-back reads (same or alternating ports) SHALL sustain one read per clk; responses return in issue order.
REQ-024 Out-of-range write: RAM command suppressed (mem_chipselect=0), request consumed, err_oor pulses.
REQ-025 Out-of-range read: RAM not accessed, request consumed, readdatavalid one clk later with readdata=0, err_oor pulses.
REQ-026 Idle: mem_chipselect=0, mem_write=0; readdata outputs SHALL read 0 when readdatavalid is low.
REQ-027 Starvation bound: a held request SHALL be granted within 2 clk of assertion.

Reset
REQ-028 reset_n low SHALL asynchronously clear rd_pending, rd_owner, last_grant (=B so A wins first), err_oor, all readdatavalid, and drive mem_clken=0, mem_chipselect=0, mem_write=0.
REQ-029 A read issued one cycle before reset assertion SHALL produce no readdatavalid after reset release.
REQ-030 Outputs SHALL resume normal operation on the first clk edge after reset_n rises.

Structure
REQ-031 Shared package onchip_mem_pkg SHALL hold ADDR_W, DATA_W, MEM_WORDS defaults and the port-id enum (PORT_A, PORT_B).
REQ-032 One sub-module, rr_arb2 (two-requester round-robin with last_grant register), SHALL be instantiated; all remaining logic is flat.

Verification
REQ-033 A writes 0x12345678 to addr 0x0010 alone -> A waitrequest 0 same cycle, mem_write=1 addr 0x0010; later A read returns 0x12345678 one clk after issue.
REQ-034 A and B both read in the same cycle after reset -> A granted first, B waitrequest 1 one cycle, B granted next; readdatavalid on A then B in consecutive cycles.
REQ-035 A and B both stream continuous reads for 16 cycles -> grants strictly alternate, 8 each, no gaps in readdatavalid.
REQ-036 B writes addr 17740 with byteenable 0xF -> mem_chipselect stays 0, err_oor pulses once; B read of 17740 -> readdata=0 with readdatavalid one clk later.
REQ-037 Byte write 0xAA with byteenable 0x4 to addr 5 holding 0x00000000 -> read returns 0x00AA0000.
REQ-038 reset_n asserted the cycle after A read issue -> no readdatavalid observed; all outputs at reset values while reset_n low.
